// File: rtl/mac_vector_sequencer.sv
// Operand sequencer in front of the macish accumulator: streams vector elements into the MAC,
// drains its two-edge pipeline with bubbles and buffers each finished dot product with its length.
`timescale 1ns/1ps
module mac_vector_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              mac_aclr,
  output logic              mac_clken,
  output logic              mac_sload,
  output logic [DATA_W-1:0] mac_dataa,
  output logic [DATA_W-1:0] mac_datab,
  input  logic [ACC_W-1:0]  mac_adder_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic              first_r;
  logic              t1_r;
  logic              cap_pending_r;
  logic [LEN_W-1:0]  cap_len_r;
  logic              cap_ovf_r;
  logic [LEN_W-1:0]  cnt_r;
  logic              ovf_r;
  logic [LEN_W-1:0]  len_r;
  logic              len_ovf_r;
  logic              out_valid_r;
  logic [ACC_W-1:0]  out_sum_r;
  logic [LEN_W-1:0]  out_len_r;
  logic              out_ovf_r;

  logic              stall_s;
  logic              in_ready_s;
  logic              issue_s;
  logic              bubble_s;
  logic              advance_s;
  logic              capture_s;
  logic              sload_s;
  logic [DATA_W-1:0] dataa_s;
  logic [DATA_W-1:0] datab_s;
  logic [LEN_W-1:0]  cnt_next_s;
  logic              ovf_next_s;

  // Handshake, MAC advance and capture decisions.
  always_comb begin
    stall_s    = cap_pending_r & out_valid_r & ~out_ready;
    // Nothing is accepted while the block is held in reset.
    in_ready_s = ~stall_s & aclr_n;
    issue_s    = in_valid & in_ready_s;
    bubble_s   = t1_r & ~issue_s & ~stall_s;
    advance_s  = issue_s | bubble_s;
    capture_s  = cap_pending_r & (~out_valid_r | out_ready);
    if (issue_s) begin
      dataa_s = in_a;
      datab_s = in_b;
      sload_s = first_r;
    end else begin
      dataa_s = {DATA_W{1'b0}};
      datab_s = {DATA_W{1'b0}};
      sload_s = 1'b0;
    end
  end

  // Element count including the pair being issued, saturating at LEN_MAX.
  always_comb begin
    cnt_next_s = LEN_ONE;
    ovf_next_s = 1'b0;
    if (first_r) begin
      cnt_next_s = LEN_ONE;
      ovf_next_s = 1'b0;
    end else if (cnt_r == LEN_MAX) begin
      cnt_next_s = LEN_MAX;
      ovf_next_s = 1'b1;
    end else begin
      cnt_next_s = cnt_r + LEN_ONE;
      ovf_next_s = ovf_r;
    end
  end

  // Tracks the MAC pipeline: t1 marks a last pair still one edge away from the accumulator.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      first_r       <= 1'b1;
      t1_r          <= 1'b0;
      cap_pending_r <= 1'b0;
      cap_len_r     <= {LEN_W{1'b0}};
      cap_ovf_r     <= 1'b0;
    end else begin
      if (issue_s) begin
        first_r <= in_last;
      end
      if (advance_s) begin
        t1_r <= issue_s & in_last;
      end
      // len_r may already be reused by a following single-element vector, so snapshot it here.
      if (advance_s && t1_r) begin
        cap_pending_r <= 1'b1;
        cap_len_r     <= len_r;
        cap_ovf_r     <= len_ovf_r;
      end else if (capture_s) begin
        cap_pending_r <= 1'b0;
      end
    end
  end

  // Per-vector element counter; the final count is latched when the last pair issues.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_r     <= {LEN_W{1'b0}};
      ovf_r     <= 1'b0;
      len_r     <= {LEN_W{1'b0}};
      len_ovf_r <= 1'b0;
    end else if (issue_s) begin
      if (in_last) begin
        len_r     <= cnt_next_s;
        len_ovf_r <= ovf_next_s;
        cnt_r     <= {LEN_W{1'b0}};
        ovf_r     <= 1'b0;
      end else begin
        cnt_r     <= cnt_next_s;
        ovf_r     <= ovf_next_s;
      end
    end
  end

  // One-entry result buffer; capture samples the accumulator before any same-edge advance.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_len_r   <= {LEN_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= mac_adder_out;
      out_len_r   <= cap_len_r;
      out_ovf_r   <= cap_ovf_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign mac_aclr  = ~aclr_n;
  assign mac_clken = advance_s;
  assign mac_sload = sload_s;
  assign mac_dataa = dataa_s;
  assign mac_datab = datab_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_len   = out_len_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Bench for mac_vector_sequencer: behavioural MAC, dot-product scoreboard, cycle table,
// directed corner sequences and randomized vectors.
`timescale 1ns/1ps
module tb_mac_vector_sequencer;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_a, in_b;
  logic        mac_aclr, mac_clken, mac_sload;
  logic [7:0]  mac_dataa, mac_datab;
  logic [15:0] mac_adder_out;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_len;

  always #5 clk = ~clk;

  mac_vector_sequencer #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
    .clk(clk), .aclr_n(aclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_aclr(mac_aclr), .mac_clken(mac_clken), .mac_sload(mac_sload),
    .mac_dataa(mac_dataa), .mac_datab(mac_datab), .mac_adder_out(mac_adder_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_len(out_len),
    .out_ovf(out_ovf)
  );

  // Behavioural MAC: operands registered on one clken edge, accumulated on the next.
  logic [15:0] mac_ra, mac_rb, mac_acc;
  logic        mac_rs;
  always @(posedge clk or posedge mac_aclr) begin
    if (mac_aclr) begin
      mac_ra <= 16'd0; mac_rb <= 16'd0; mac_rs <= 1'b0; mac_acc <= 16'd0;
    end else if (mac_clken) begin
      mac_ra  <= {8'd0, mac_dataa};
      mac_rb  <= {8'd0, mac_datab};
      mac_rs  <= mac_sload;
      mac_acc <= (mac_rs ? 16'd0 : mac_acc) + mac_ra * mac_rb;
    end
  end
  assign mac_adder_out = mac_acc;

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  len;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  res_t mon_r;
  int   ref_acc = 0;
  int   ref_n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_done;

  // Reference: dot product of every accepted vector, length saturated at 255.
  always @(negedge clk) begin
    if (!aclr_n) begin
      ref_acc = 0;
      ref_n = 0;
    end else begin
      if (in_valid && in_ready) begin
        ref_acc = ref_acc + int'(in_a) * int'(in_b);
        ref_n = ref_n + 1;
        if (in_last) begin
          mon_r.sum = ref_acc[15:0];
          mon_r.len = (ref_n > 255) ? 8'd255 : ref_n[7:0];
          mon_r.ovf = (ref_n > 255);
          exp_q.push_back(mon_r);
          ref_acc = 0;
          ref_n = 0;
        end
      end
      if (out_valid && out_ready) begin
        mon_r = {out_sum, out_len, out_ovf};
        got_q.push_back(mon_r);
      end
    end
  end

  typedef struct {
    logic v; logic [7:0] a; logic [7:0] b; logic last; logic rdy;
    logic e_ir; logic e_ck; logic e_sl; logic [7:0] e_da; logic [7:0] e_db;
    logic e_ov; logic [15:0] e_sum; logic [7:0] e_len;
  } row_t;
  row_t tbl[13];

  function automatic row_t mk(logic v, logic [7:0] a, logic [7:0] b, logic last, logic rdy,
                              logic ir, logic ck, logic sl, logic [7:0] da, logic [7:0] db,
                              logic ov, logic [15:0] sum, logic [7:0] len);
    row_t r;
    r.v = v; r.a = a; r.b = b; r.last = last; r.rdy = rdy;
    r.e_ir = ir; r.e_ck = ck; r.e_sl = sl; r.e_da = da; r.e_db = db;
    r.e_ov = ov; r.e_sum = sum; r.e_len = len;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int k;
    k = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low want=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_const(input string nm, input logic [15:0] s, input logic [7:0] l,
                              input logic o);
    res_t g;
    res_t d;
    wait_got(1);
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=no_result want=%0d", nm, s);
    end else begin
      g = got_q.pop_front();
      if (exp_q.size() > 0) d = exp_q.pop_front();
      chk(nm, {7'd0, g}, {7'd0, s, l, o});
    end
  endtask

  initial begin
    int n;
    int vlen;
    aclr_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
    out_ready = 1'b0; rnd_done = 1'b0;

    tbl[0]  = mk(1'b1, 8'd3, 8'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd4, 1'b0, 16'd0, 8'd0);
    tbl[1]  = mk(1'b1, 8'd5, 8'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'd6, 1'b0, 16'd0, 8'd0);
    tbl[2]  = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    tbl[3]  = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    tbl[4]  = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 16'd42, 8'd2);
    tbl[5]  = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    tbl[6]  = mk(1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0, 16'd0, 8'd0);
    tbl[7]  = mk(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 16'd0, 8'd0);
    tbl[8]  = mk(1'b1, 8'd7, 8'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7, 8'd9, 1'b0, 16'd0, 8'd0);
    tbl[9]  = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 8'd0);
    tbl[10] = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 16'd5, 8'd2);
    tbl[11] = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 16'd63, 8'd1);
    tbl[12] = mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 8'd0);

    // Reset state.
    @(negedge clk);
    chk("rst_out", {7'd0, out_valid, out_ovf, out_len, out_sum}, 32'd0);
    chk("rst_mac", {13'd0, mac_aclr, mac_clken, mac_sload, mac_dataa, mac_datab},
        {13'd0, 1'b1, 18'd0});
    @(posedge clk); #1;
    aclr_n = 1'b1;
    @(posedge clk); #1;

    // Cycle table: bubble drain, latency, back-to-back vectors.
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v; in_a = tbl[i].a; in_b = tbl[i].b; in_last = tbl[i].last;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_ctl", i),
          {12'd0, in_ready, mac_clken, mac_sload, mac_dataa, mac_datab, out_valid},
          {12'd0, tbl[i].e_ir, tbl[i].e_ck, tbl[i].e_sl, tbl[i].e_da, tbl[i].e_db, tbl[i].e_ov});
      if (tbl[i].e_ov)
        chk($sformatf("row%0d_res", i), {8'd0, out_sum, out_len},
            {8'd0, tbl[i].e_sum, tbl[i].e_len});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
    expect_const("vec_42", 16'd42, 8'd2, 1'b0);
    expect_const("vec_5", 16'd5, 8'd2, 1'b0);
    expect_const("vec_63", 16'd63, 8'd1, 1'b0);

    // Accumulator wraps modulo 2^16.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    expect_const("wrap", 16'd64514, 8'd2, 1'b0);

    // Result held while the consumer stalls; nothing may be lost.
    out_ready = 1'b0;
    send(8'd10, 8'd10, 1'b1);
    send(8'd20, 8'd20, 1'b1);
    send(8'd1, 8'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready_clken", {30'd0, in_ready, mac_clken}, 32'd0);
      chk("stall_hold", {15'd0, out_valid, out_sum}, {15'd0, 1'b1, 16'd100});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    expect_const("stall_100", 16'd100, 8'd1, 1'b0);
    expect_const("stall_400", 16'd400, 8'd1, 1'b0);
    expect_const("stall_1", 16'd1, 8'd1, 1'b0);

    // Length saturation and overflow flag.
    for (int i = 0; i < 300; i++) send(8'd1, 8'd1, i == 299);
    expect_const("ovf_300", 16'd300, 8'd255, 1'b1);

    // Randomized vectors with a randomly stalling consumer.
    fork
      begin
        for (int v = 0; v < 40; v++) begin
          vlen = $urandom_range(1, 5);
          for (int e = 0; e < vlen; e++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e == vlen - 1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = exp_q.size();
    wait_got(n);
    chk("rand_count", got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("rand_res", {7'd0, got_q.pop_front()}, {7'd0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();

    // Reset in mid-vector discards the partial sum.
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    aclr_n = 1'b0;
    @(negedge clk);
    chk("midrst", {29'd0, mac_aclr, out_valid, mac_clken}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    aclr_n = 1'b1;
    @(posedge clk); #1;
    send(8'd4, 8'd4, 1'b1);
    expect_const("after_rst", 16'd16, 8'd1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    chk("no_extra", got_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
